mem_arbiter: RTL and testbench
==============================

Name: mem_arbiter

Overview:
- Shares one single-port 32-bit memory bus between the IF-stage instruction fetch and the MEM-stage load/store.
- Sits between the pipeline top and the external memory.
- Grants one requester at a time and holds the bus stable until the memory acknowledges.
- Returns read data with a one-cycle ack pulse and raises a stall request to the pipeline control while any access is outstanding.

Parameters:
- ADDR_W, 32, address width of all buses
- DATA_W, 32, data width of all buses
- WAIT_MAX, 16, maximum cycles to wait for m_ack before the access is aborted
- D_STREAK, 4, maximum consecutive data grants while if_req is pending before fetch is forced

Ports:
- clk  in  1  clock; all logic on rising edge
- rst  in  1  synchronous reset, active-high
- if_req  in  1  instruction fetch request; held until if_ack
- if_addr  in  ADDR_W  fetch address
- if_rdata  out  DATA_W  fetched instruction; valid when if_ack=1
- if_ack  out  1  one-cycle completion pulse for fetch
- d_req  in  1  data access request; held until d_ack
- d_we  in  1  1=store, 0=load
- d_addr  in  ADDR_W  data address
- d_wdata  in  DATA_W  store data
- d_sel  in  4  byte enables
- d_rdata  out  DATA_W  load data; valid when d_ack=1
- d_ack  out  1  one-cycle completion pulse for data
- m_req  out  1  memory request
- m_we  out  1  memory write enable
- m_addr  out  ADDR_W  memory address
- m_wdata  out  DATA_W  memory write data
- m_sel  out  4  memory byte enables; 4'b1111 for fetch
- m_rdata  in  DATA_W  memory read data; valid with m_ack
- m_ack  in  1  memory completion, one cycle
- stall_req_o  out  1  pipeline stall request
- err_o  out  1  sticky timeout flag

Behaviour:
- Reset (rst=1 at a clock edge):
  - state=IDLE.
  - All outputs 0: m_*, acks, rdata regs, err_o, counters.
  - Reset mid-transaction abandons the access; no ack is issued.
- FSM states: IDLE, BUSY_D, BUSY_I.
- IDLE grant order:
  - d_req=1 and (if_req=0 or streak<D_STREAK) -> BUSY_D; register d_we/d_addr/d_wdata/d_sel onto m_*; m_req<=1.
  - else if_req=1 -> BUSY_I; m_we<=0, m_addr<=if_addr, m_sel<=4'b1111, m_wdata<=0, m_req<=1.
  - else stay in IDLE.
- Streak counter:
  - Increments on each data grant made while if_req=1.
  - Clears on any fetch grant, or on a data grant with if_req=0.
  - streak==D_STREAK forces the next grant to fetch if if_req=1.
- BUSY_x:
  - m_* held constant; wait counter increments each cycle.
  - On m_ack=1: capture m_rdata into the granted rdata reg (d_rdata also loads on stores), pulse the granted ack for 1 cycle, m_req<=0, -> IDLE, wait counter cleared.
  - Timeout: wait counter reaches WAIT_MAX-1 without m_ack. Next edge: m_req<=0, rdata<=0, ack pulsed, err_o<=1 (sticky until rst), -> IDLE.
  - An m_ack arriving in IDLE is ignored.
- Latency:
  - req first seen in IDLE at edge N -> m_req high after N.
  - m_ack sampled at edge M -> ack/rdata valid during cycle after M.
  - Zero-wait memory gives 2 cycles from req to ack.
  - Back-to-back: IDLE re-arbitrates in the ack cycle, so the next m_req rises one cycle after the ack.
- rdata regs hold their value until the next completion for that requester.
- A requester dropping req mid-access does not abort it; the access completes and the ack is still pulsed.
- stall_req_o = (d_req & ~d_ack) | (if_req & ~if_ack), combinational; 0 during reset.
- Simultaneous d_req and if_req in IDLE: data wins unless the streak limit has been reached.

Decomposition:
- Shared defines (project defines file):
  - state encodings ARB_IDLE/ARB_BUSY_D/ARB_BUSY_I
  - full-word select constant
  - reset/enable level macros already in use
- Single module; no sub-module. The wait and streak counters are inline.

Test Plan:
- Zero-wait fetch: if_req=1, if_addr=0x0000_0040; memory acks next cycle with 0x2401_0005 -> m_addr=0x40, m_sel=F, if_ack one cycle with if_rdata=0x24010005, 2 cycles after request.
- Store with 3 wait states: d_req, d_we=1, d_addr=0x100, d_wdata=0xDEAD_BEEF, d_sel=4'b0011 -> m_* stable for 4 cycles, d_ack one pulse, stall_req_o high until the ack cycle.
- Simultaneous d_req and if_req -> data granted first; fetch granted on the cycle after d_ack.
- Continuous d_req plus if_req with D_STREAK=4 -> four data grants, then one fetch grant, then data resumes.
- Memory never acks, WAIT_MAX=16 -> m_req drops after 16 cycles; ack pulsed with rdata=0; err_o=1 and stays 1 until rst.
- rst asserted during BUSY_D -> next cycle m_req=0, no ack pulse, state IDLE; a subsequent fetch completes normally.

Source files
------------

// File: rtl/mem_arbiter_pkg.sv
// Shared types and constants for the IF/MEM memory bus arbiter.
package mem_arbiter_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE   = 2'd0,
    ARB_BUSY_D = 2'd1,
    ARB_BUSY_I = 2'd2
  } arb_state_e;

  localparam logic [3:0] SEL_FULL = 4'b1111;

endpackage

// File: rtl/mem_arbiter.sv
// Arbitrates one single-port memory bus between instruction fetch and load/store.
// Data wins ties until D_STREAK back-to-back data grants starve a pending fetch.
import mem_arbiter_pkg::*;

module mem_arbiter #(
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter int WAIT_MAX = 16,
  parameter int D_STREAK = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_ack,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  input  logic [3:0]        d_sel,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_ack,
  output logic              m_req,
  output logic              m_we,
  output logic [ADDR_W-1:0] m_addr,
  output logic [DATA_W-1:0] m_wdata,
  output logic [3:0]        m_sel,
  input  logic [DATA_W-1:0] m_rdata,
  input  logic              m_ack,
  output logic              stall_req_o,
  output logic              err_o
);

  localparam int WC_W = $clog2(WAIT_MAX + 1);
  localparam int SK_W = $clog2(D_STREAK + 1);
  localparam logic [WC_W-1:0] WAIT_LAST  = WC_W'(WAIT_MAX - 1);
  localparam logic [SK_W-1:0] STREAK_LIM = SK_W'(D_STREAK);

  arb_state_e      state, state_nxt;
  logic [WC_W-1:0] wait_cnt;
  logic [SK_W-1:0] streak;
  logic            grant_d, grant_i, done, tmo;

  always_ff @(posedge clk) begin
    if (rst) state <= ARB_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    grant_d   = 1'b0;
    grant_i   = 1'b0;
    done      = 1'b0;
    tmo       = 1'b0;
    case (state)
      ARB_IDLE: begin
        if (d_req && (!if_req || streak < STREAK_LIM)) begin
          grant_d   = 1'b1;
          state_nxt = ARB_BUSY_D;
        end else if (if_req) begin
          grant_i   = 1'b1;
          state_nxt = ARB_BUSY_I;
        end
      end
      ARB_BUSY_D, ARB_BUSY_I: begin
        // a real ack on the last wait cycle still beats the timeout
        if (m_ack) begin
          done      = 1'b1;
          state_nxt = ARB_IDLE;
        end else if (wait_cnt == WAIT_LAST) begin
          tmo       = 1'b1;
          state_nxt = ARB_IDLE;
        end
      end
      default: state_nxt = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      m_req    <= 1'b0;
      m_we     <= 1'b0;
      m_addr   <= '0;
      m_wdata  <= '0;
      m_sel    <= '0;
      if_ack   <= 1'b0;
      d_ack    <= 1'b0;
      if_rdata <= '0;
      d_rdata  <= '0;
      err_o    <= 1'b0;
      wait_cnt <= '0;
      streak   <= '0;
    end else begin
      if_ack <= 1'b0;
      d_ack  <= 1'b0;
      if (grant_d) begin
        m_req    <= 1'b1;
        m_we     <= d_we;
        m_addr   <= d_addr;
        m_wdata  <= d_wdata;
        m_sel    <= d_sel;
        wait_cnt <= '0;
        streak   <= if_req ? streak + SK_W'(1) : '0;
      end else if (grant_i) begin
        m_req    <= 1'b1;
        m_we     <= 1'b0;
        m_addr   <= if_addr;
        m_wdata  <= '0;
        m_sel    <= SEL_FULL;
        wait_cnt <= '0;
        streak   <= '0;
      end else if (done || tmo) begin
        m_req    <= 1'b0;
        wait_cnt <= '0;
        if (tmo) err_o <= 1'b1;
        if (state == ARB_BUSY_D) begin
          d_ack   <= 1'b1;
          d_rdata <= done ? m_rdata : '0;
        end else begin
          if_ack   <= 1'b1;
          if_rdata <= done ? m_rdata : '0;
        end
      end else if (state != ARB_IDLE) begin
        wait_cnt <= wait_cnt + WC_W'(1);
      end
    end
  end

  assign stall_req_o = ~rst & ((d_req & ~d_ack) | (if_req & ~if_ack));

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: scripted requesters, a wait-state memory model and a grant/ack scoreboard.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req, if_ack, d_req, d_we, d_ack;
  logic [31:0] if_addr, if_rdata, d_addr, d_wdata, d_rdata;
  logic [3:0]  d_sel, m_sel;
  logic        m_req, m_we, m_ack, stall_req_o, err_o;
  logic [31:0] m_addr, m_wdata, m_rdata;

  always #5 clk = ~clk;

  mem_arbiter #(.ADDR_W(32), .DATA_W(32), .WAIT_MAX(16), .D_STREAK(4)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ack(if_ack),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_sel(d_sel),
    .d_rdata(d_rdata), .d_ack(d_ack),
    .m_req(m_req), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata), .m_sel(m_sel),
    .m_rdata(m_rdata), .m_ack(m_ack),
    .stall_req_o(stall_req_o), .err_o(err_o)
  );

  typedef struct {
    bit          is_d;
    logic [31:0] addr;
    logic        we;
    logic [3:0]  sel;
    logic [31:0] wdata;
    logic [31:0] rdata;
  } txn_t;

  txn_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] mem_fn(input logic [31:0] a);
    return (a == 32'h40) ? 32'h2401_0005 : (a ^ 32'h5A5A_F00F);
  endfunction

  // memory: acks after mem_wait extra cycles of m_req, or never when mem_noack
  int   mem_wait  = 0;
  bit   mem_noack = 1'b0;
  int   mcnt      = 0;
  initial begin m_ack = 1'b0; m_rdata = 32'h0; end
  always @(posedge clk) begin
    #1;
    if (m_req && !mem_noack) begin
      if (mcnt == mem_wait) begin
        m_ack = 1'b1; m_rdata = mem_fn(m_addr); mcnt = 0;
      end else begin
        m_ack = 1'b0; mcnt++;
      end
    end else begin
      m_ack = 1'b0; m_rdata = 32'hBAD0_BAD0; mcnt = 0;
    end
  end

  // requesters: drop or advance their request in the ack cycle
  int d_left = 0;
  int i_left = 0;
  always @(negedge clk) begin
    if (d_ack) begin
      d_left--;
      if (d_left <= 0) d_req = 1'b0; else d_addr = d_addr + 32'h4;
    end
    if (if_ack) begin
      i_left--;
      if (i_left <= 0) if_req = 1'b0; else if_addr = if_addr + 32'h4;
    end
  end

  // scoreboard: grant contents and stability on m_*, ack source and rdata
  logic mreq_q = 1'b0;
  txn_t cur;
  logic        bq_we;
  logic [31:0] bq_addr, bq_wdata;
  logic [3:0]  bq_sel;
  always @(negedge clk) begin
    if (!rst) begin
      if (m_req && !mreq_q) begin
        chk("grant_pending", 32'(exp_q.size() > 0), 32'd1);
        if (exp_q.size() > 0) begin
          cur = exp_q[0];
          chk("grant_addr", m_addr, cur.addr);
          chk("grant_we", 32'(m_we), 32'(cur.we));
          chk("grant_sel", 32'(m_sel), 32'(cur.sel));
          chk("grant_wdata", m_wdata, cur.wdata);
        end
        bq_we = m_we; bq_addr = m_addr; bq_wdata = m_wdata; bq_sel = m_sel;
      end else if (m_req) begin
        chk("hold_bus", {m_addr ^ bq_addr} | {m_wdata ^ bq_wdata} | 32'({m_sel ^ bq_sel, m_we ^ bq_we}), 32'd0);
      end
      if (if_ack || d_ack) begin
        chk("ack_pending", 32'(exp_q.size() > 0), 32'd1);
        chk("ack_onehot", 32'(if_ack & d_ack), 32'd0);
        if (exp_q.size() > 0) begin
          cur = exp_q.pop_front();
          chk("ack_src", 32'(d_ack), 32'(cur.is_d));
          chk("ack_rdata", d_ack ? d_rdata : if_rdata, cur.rdata);
        end
      end
      mreq_q = m_req;
    end else begin
      mreq_q = 1'b0;
    end
  end

  function automatic txn_t mk(input bit is_d, input logic [31:0] a, input logic we,
                              input logic [3:0] sel, input logic [31:0] wd, input logic [31:0] rd);
    txn_t t;
    t.is_d = is_d; t.addr = a; t.we = we; t.sel = sel; t.wdata = wd; t.rdata = rd;
    return t;
  endfunction

  task automatic wait_ack(input int max, output int cyc);
    cyc = 0;
    do begin
      @(posedge clk); #1;
      cyc++;
    end while (!(if_ack || d_ack) && cyc < max);
    if (!(if_ack || d_ack)) chk("ack_wait_bound", 32'(cyc), 32'(-1));
  endtask

  int cyc;

  initial begin
    rst = 1'b1;
    if_req = 1'b1; if_addr = 32'h0; d_req = 1'b1; d_we = 1'b0;
    d_addr = 32'h0; d_wdata = 32'h0; d_sel = 4'h0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_m_req", 32'(m_req), 32'd0);
    chk("rst_m_bus", m_addr | m_wdata | 32'({m_sel, m_we}), 32'd0);
    chk("rst_acks", 32'({if_ack, d_ack}), 32'd0);
    chk("rst_rdata", if_rdata | d_rdata, 32'd0);
    chk("rst_err", 32'(err_o), 32'd0);
    chk("rst_stall", 32'(stall_req_o), 32'd0);
    if_req = 1'b0; d_req = 1'b0;
    rst = 1'b0;
    @(posedge clk); #1;
    chk("idle_stall", 32'(stall_req_o), 32'd0);

    // zero-wait fetch
    mem_wait = 0;
    exp_q.push_back(mk(0, 32'h40, 1'b0, 4'hF, 32'h0, 32'h2401_0005));
    if_addr = 32'h40; i_left = 1; if_req = 1'b1;
    #0 chk("fetch_stall", 32'(stall_req_o), 32'd1);
    wait_ack(10, cyc);
    chk("fetch_latency", 32'(cyc), 32'd2);
    chk("fetch_ack_stall", 32'(stall_req_o), 32'd0);

    // store with 3 wait states; stall held until the ack cycle
    @(posedge clk); #1;
    mem_wait = 3;
    exp_q.push_back(mk(1, 32'h100, 1'b1, 4'b0011, 32'hDEAD_BEEF, mem_fn(32'h100)));
    d_addr = 32'h100; d_we = 1'b1; d_wdata = 32'hDEAD_BEEF; d_sel = 4'b0011;
    d_left = 1; d_req = 1'b1;
    cyc = 0;
    do begin
      @(posedge clk); #1; cyc++;
      chk("store_stall", 32'(stall_req_o), 32'(!d_ack));
    end while (!d_ack && cyc < 20);
    chk("store_latency", 32'(cyc), 32'd5);

    // simultaneous requests: data first, fetch right after d_ack
    @(posedge clk); #1;
    mem_wait = 1;
    exp_q.push_back(mk(1, 32'h200, 1'b0, 4'hF, 32'h0, mem_fn(32'h200)));
    exp_q.push_back(mk(0, 32'h300, 1'b0, 4'hF, 32'h0, mem_fn(32'h300)));
    d_we = 1'b0; d_addr = 32'h200; d_wdata = 32'h0; d_sel = 4'hF; d_left = 1;
    if_addr = 32'h300; i_left = 1;
    d_req = 1'b1; if_req = 1'b1;
    wait_ack(20, cyc);
    chk("tie_first_is_d", 32'(d_ack), 32'd1);
    wait_ack(20, cyc);
    chk("tie_fetch_gap", 32'(cyc), 32'd3);

    // streak limit: 4 data grants, then a forced fetch, then data resumes
    @(posedge clk); #1;
    mem_wait = 0;
    for (int k = 0; k < 4; k++)
      exp_q.push_back(mk(1, 32'h400 + 32'(4 * k), 1'b0, 4'hF, 32'h0, mem_fn(32'h400 + 32'(4 * k))));
    exp_q.push_back(mk(0, 32'h500, 1'b0, 4'hF, 32'h0, mem_fn(32'h500)));
    for (int k = 4; k < 6; k++)
      exp_q.push_back(mk(1, 32'h400 + 32'(4 * k), 1'b0, 4'hF, 32'h0, mem_fn(32'h400 + 32'(4 * k))));
    d_addr = 32'h400; d_left = 6; if_addr = 32'h500; i_left = 1;
    d_req = 1'b1; if_req = 1'b1;
    for (int k = 0; k < 7; k++) begin
      wait_ack(20, cyc);
      chk("streak_src", 32'(if_ack), 32'(k == 4));
    end

    // timeout: memory never acks
    @(posedge clk); #1;
    mem_noack = 1'b1;
    chk("pre_tmo_err", 32'(err_o), 32'd0);
    exp_q.push_back(mk(1, 32'h600, 1'b0, 4'hF, 32'h0, 32'h0));
    d_addr = 32'h600; d_left = 1; d_req = 1'b1;
    wait_ack(40, cyc);
    chk("tmo_latency", 32'(cyc), 32'd17);
    chk("tmo_err", 32'(err_o), 32'd1);
    @(posedge clk); #1;
    chk("tmo_m_req", 32'(m_req), 32'd0);
    mem_noack = 1'b0;
    exp_q.push_back(mk(0, 32'h40, 1'b0, 4'hF, 32'h0, 32'h2401_0005));
    if_addr = 32'h40; i_left = 1; if_req = 1'b1;
    wait_ack(10, cyc);
    chk("err_sticky", 32'(err_o), 32'd1);

    // reset during BUSY_D abandons the access
    @(posedge clk); #1;
    mem_noack = 1'b1;
    exp_q.push_back(mk(1, 32'h700, 1'b0, 4'hF, 32'h0, 32'h0));
    d_addr = 32'h700; d_left = 1; d_req = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("busy_m_req", 32'(m_req), 32'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("mid_rst_m_req", 32'(m_req), 32'd0);
    chk("mid_rst_ack", 32'({if_ack, d_ack}), 32'd0);
    chk("mid_rst_err", 32'(err_o), 32'd0);
    d_req = 1'b0; d_left = 0;
    exp_q.delete();
    rst = 1'b0;
    mem_noack = 1'b0;
    repeat (4) begin
      @(posedge clk); #1;
      chk("post_rst_quiet", 32'({m_req, if_ack, d_ack}), 32'd0);
    end
    exp_q.push_back(mk(0, 32'h40, 1'b0, 4'hF, 32'h0, 32'h2401_0005));
    if_addr = 32'h40; i_left = 1; if_req = 1'b1;
    wait_ack(10, cyc);
    chk("post_rst_fetch", 32'(cyc), 32'd2);

    @(posedge clk); #1;
    chk("sb_drained", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
